// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of a 4x1 mux.
// Registered grant/select outputs with a one-cycle idle gap between grants.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic       preempt
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t            state;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        pick;
    logic [1:0]        cur;
    logic              expired;

    // The select lines already hold the granted channel index.
    assign cur     = {s1, s0};
    assign expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && ((req & ~gnt) != 4'b0000);

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)])
                pick = ptr + 2'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            s1       <= 1'b0;
            s0       <= 1'b0;
            valid    <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    preempt <= 1'b0;
                    if (req != 4'b0000) begin
                        gnt      <= 4'b0001 << pick;
                        {s1, s0} <= pick;
                        valid    <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[cur] || expired) begin
                        // A voluntary drop wins over a coincident expiry.
                        preempt <= req[cur];
                        gnt     <= 4'b0000;
                        valid   <= 1'b0;
                        ptr     <= cur + 2'd1;
                        state   <= IDLE;
                    end else begin
                        preempt <= 1'b0;
                        if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed-vector bench for mux_sel_arbiter (MAX_HOLD=3).
// Observed tuple is {gnt, s1, s0, valid, preempt}, sampled 1ns after each rising edge.
module tb_mux_sel_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1, s0, valid, preempt;
    int         n_tests = 0;
    int         n_fail  = 0;

    mux_sel_arbiter #(.MAX_HOLD(3), .HOLD_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .s1(s1), .s0(s0), .valid(valid), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111;
        tick(); tick();
        n_tests++;
        if ({gnt, s1, s0, valid, preempt} !== 8'b0000_00_0_0) begin
            n_fail++;
            $display("FAIL reset: got %b want 00000000", {gnt, s1, s0, valid, preempt});
        end
        req = 4'b0000; rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if ({gnt, s1, s0, valid, preempt} !== 8'b0100_10_1_0) begin
                n_fail++;
                $display("FAIL single_hold c%0d: got %b want 01001010", c, {gnt, s1, s0, valid, preempt});
            end
        end
        req = 4'b0000;
        tick();
        n_tests++;
        if ({gnt, s1, s0, valid, preempt} !== 8'b0000_10_0_0) begin
            n_fail++;
            $display("FAIL single_release: got %b want 00001000", {gnt, s1, s0, valid, preempt});
        end
    endtask

    task automatic test_round_robin();
        int ch;
        logic [7:0] exp;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            ch = g % 4;
            for (int c = 0; c < 3; c++) begin
                tick();
                exp = {4'b0001 << ch, 2'(ch), 1'b1, 1'b0};
                n_tests++;
                if ({gnt, s1, s0, valid, preempt} !== exp) begin
                    n_fail++;
                    $display("FAIL rr_grant g%0d c%0d: got %b want %b", g, c, {gnt, s1, s0, valid, preempt}, exp);
                end
            end
            tick();
            exp = {4'b0000, 2'(ch), 1'b0, 1'b1};
            n_tests++;
            if ({gnt, s1, s0, valid, preempt} !== exp) begin
                n_fail++;
                $display("FAIL rr_preempt g%0d: got %b want %b", g, {gnt, s1, s0, valid, preempt}, exp);
            end
        end
        req = 4'b0000;
        tick();
        n_tests++;
        if ({gnt, valid, preempt} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL rr_idle: got %b want 000000", {gnt, valid, preempt});
        end
    endtask

    task automatic test_wrap();
        req = 4'b1000;
        tick(); tick();
        n_tests++;
        if ({gnt, s1, s0, valid, preempt} !== 8'b1000_11_1_0) begin
            n_fail++;
            $display("FAIL wrap_ch3: got %b want 10001110", {gnt, s1, s0, valid, preempt});
        end
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        n_tests++;
        if ({gnt, s1, s0, valid, preempt} !== 8'b0001_00_1_0) begin
            n_fail++;
            $display("FAIL wrap_next: got %b want 00010010", {gnt, s1, s0, valid, preempt});
        end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_sole_requester();
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_tests++;
            if ({gnt, s1, s0, valid, preempt} !== 8'b0010_01_1_0) begin
                n_fail++;
                $display("FAIL sole c%0d: got %b want 00100110", c, {gnt, s1, s0, valid, preempt});
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        // ptr is 2 here; grant and release ch2 so ptr becomes 3 before the reset.
        req = 4'b0100; tick();
        req = 4'b0000; tick();
        req = 4'b0100; tick(); tick();
        n_tests++;
        if ({gnt, s1, s0, valid} !== 7'b0100_10_1) begin
            n_fail++;
            $display("FAIL mid_pre: got %b want 0100101", {gnt, s1, s0, valid});
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({gnt, s1, s0, valid, preempt} !== 8'b0000_00_0_0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 00000000", {gnt, s1, s0, valid, preempt});
        end
        rst = 1'b0; req = 4'b1100;
        tick();
        n_tests++;
        if ({gnt, s1, s0, valid, preempt} !== 8'b0100_10_1_0) begin
            n_fail++;
            $display("FAIL mid_ptr: got %b want 01001010", {gnt, s1, s0, valid, preempt});
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_sole_requester();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
